// File: rtl/cellcore_pkg.sv
// Shared definitions for the cell core: opcode encodings, register IDs and
// the branch-control state enum.
package cellcore_pkg;

    localparam logic [3:0] OP_UNL  = 4'hC;
    localparam logic [3:0] OP_JUMP = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hE;

    localparam logic [3:0] REG_MY  = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } cell_state_e;

    // True for opcodes that transfer control or stop, and so never write registers.
    function automatic logic is_flow_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_JUMP, OP_CALL, OP_RET, OP_HALT: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cell_return_stack.sv
// Return-address stack for the cell branch controller. Entries are not reset;
// only the occupancy counter is, so a pop never sees stale data below sp.
module cell_return_stack
    import cellcore_pkg::*;
#(
    parameter int PC_WIDTH    = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [PC_WIDTH-1:0]                push_data,
    output logic [PC_WIDTH-1:0]                top_data,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int SLOTS = 1 << SP_W;

    logic [SP_W-1:0]     r_sp;
    logic [PC_WIDTH-1:0] r_mem [SLOTS];

    // Occupancy counter; push and pop are mutually exclusive by construction upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= {SP_W{1'b0}};
        end else if (push && !full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_sp] <= push_data;
        end
    end

    assign top_data = r_mem[r_sp - SP_W'(1)];
    assign full     = (r_sp == SP_W'(STACK_DEPTH));
    assign empty    = (r_sp == {SP_W{1'b0}});
    assign sp       = r_sp;

endmodule

// File: rtl/cell_branch_control.sv
// Per-cell branch controller: keeps a private PC, follows the broadcast
// instruction stream only while synchronized, and supports CALL/RET/HALT.
module cell_branch_control
    import cellcore_pkg::*;
#(
    parameter int REGISTER_LENGTH = 8,
    parameter int PC_WIDTH        = 12,
    parameter int STACK_DEPTH     = 4,
    parameter int PC_STEP         = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [REGISTER_LENGTH-1:0]         target_value,
    input  logic [15:0]                        instruction,
    input  logic [PC_WIDTH-1:0]                program_counter,
    input  logic                               execution_enable,
    output logic                               enable,
    output logic                               state_change_enable,
    output logic [PC_WIDTH-1:0]                local_pc,
    output logic                               synchronized,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               fault,
    output logic                               halted
);

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

    cell_state_e         r_state;
    logic [PC_WIDTH-1:0] r_local_pc;
    logic                r_fault;
    logic                r_halted;

    logic [3:0]          w_opcode;
    logic [3:0]          w_target;
    logic [PC_WIDTH-1:0] w_imm;
    logic [PC_WIDTH-1:0] w_addr;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_top;
    logic                w_sync;
    logic                w_active;
    logic                w_unl_taken;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_opcode    = instruction[15:12];
    assign w_target    = instruction[11:8];
    assign w_imm       = PC_WIDTH'(instruction[7:0]);
    assign w_addr      = PC_WIDTH'(instruction[11:0]);
    assign w_seq_pc    = r_local_pc + PC_INC;
    assign w_sync      = (r_local_pc == program_counter);
    // A diverged cell simply idles until the global PC comes back to its own.
    assign w_active    = execution_enable && w_sync && (r_state == ST_RUN) && !r_fault;
    assign w_unl_taken = (w_opcode == OP_UNL) && (target_value == {REGISTER_LENGTH{1'b0}});
    assign w_push      = w_active && (w_opcode == OP_CALL) && !w_full;
    assign w_pop       = w_active && (w_opcode == OP_RET) && !w_empty;

    cell_return_stack #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_seq_pc),
        .top_data  (w_top),
        .full      (w_full),
        .empty     (w_empty),
        .sp        (sp)
    );

    // Control FSM: local PC, run/halt/fault state and the sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_local_pc <= {PC_WIDTH{1'b0}};
            r_fault    <= 1'b0;
            r_halted   <= 1'b0;
        end else if (w_active) begin
            case (w_opcode)
                OP_UNL:  r_local_pc <= w_unl_taken ? w_imm : w_seq_pc;
                OP_JUMP: r_local_pc <= w_addr;
                OP_CALL: begin
                    if (w_full) begin
                        r_fault <= 1'b1;
                        r_state <= ST_FAULT;
                    end else begin
                        r_local_pc <= w_addr;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        r_fault <= 1'b1;
                        r_state <= ST_FAULT;
                    end else begin
                        r_local_pc <= w_top;
                    end
                end
                OP_HALT: begin
                    r_halted <= 1'b1;
                    r_state  <= ST_HALTED;
                end
                default: r_local_pc <= w_seq_pc;
            endcase
        end
    end

    // Register-write enables; w_active already excludes HALTED and FAULT.
    always_comb begin
        enable              = 1'b0;
        state_change_enable = 1'b0;
        if (w_active && !w_unl_taken && !is_flow_op(w_opcode)) begin
            enable              = 1'b1;
            state_change_enable = (w_target == REG_MY);
        end else begin
            enable              = 1'b0;
            state_change_enable = 1'b0;
        end
    end

    assign local_pc     = r_local_pc;
    assign synchronized = w_sync;
    assign fault        = r_fault;
    assign halted       = r_halted;

endmodule

// File: doc/cell_branch_control.md
CELL_BRANCH_CONTROL -- requirements
Module: cell_branch_control

Interface
REQ-001 The block SHALL expose parameter REGISTER_LENGTH, default 8, as the width of target_value.
REQ-002 The block SHALL expose parameter PC_WIDTH, default 12, as the program-counter width, legal range 12 to 16.
REQ-003 The block SHALL expose parameter STACK_DEPTH, default 4, as the number of return-stack entries, legal range 1 to 16.
REQ-004 The block SHALL expose parameter PC_STEP, default 2, as the local PC increment per executed instruction.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 target_value  input  REGISTER_LENGTH  value of the register named by the instruction's target field.
REQ-008 instruction  input  16  current broadcast instruction: opcode [15:12], target [11:8], imm8 [7:0], addr12 [11:0].
REQ-009 program_counter  input  PC_WIDTH  global PC of the broadcast instruction.
REQ-010 execution_enable  input  1  instruction valid this cycle.
REQ-011 enable  output  1  cell may write its registers this cycle.
REQ-012 state_change_enable  output  1  enable AND target equals REG_MY.
REQ-013 local_pc  output  PC_WIDTH  cell's private PC.
REQ-014 synchronized  output  1  local_pc equals program_counter.
REQ-015 sp  output  clog2(STACK_DEPTH+1)  current return-stack occupancy.
REQ-016 fault  output  1  sticky stack overflow or underflow flag.
REQ-017 halted  output  1  cell has executed HALT.

Function
REQ-018 An instruction is "active" when execution_enable, synchronized, state is RUN, and no fault; all updates below SHALL occur only on active instructions.
REQ-019 The state machine SHALL have states RUN, HALTED and FAULT; it leaves HALTED or FAULT only on reset.
REQ-020 UNL with target_value all-zero SHALL load local_pc with imm8 zero-extended; UNL with nonzero target_value SHALL advance by PC_STEP.
REQ-021 JUMP SHALL load local_pc with addr12 zero-extended to PC_WIDTH.
REQ-022 CALL SHALL push local_pc+PC_STEP (mod 2^PC_WIDTH) onto the stack, increment sp, and load addr12 zero-extended.
REQ-023 RET SHALL pop the top stack entry into local_pc and decrement sp.
REQ-024 CALL with sp==STACK_DEPTH SHALL leave the stack and local_pc unchanged, set fault, and enter FAULT.
REQ-025 RET with sp==0 SHALL leave the stack and local_pc unchanged, set fault, and enter FAULT.
REQ-026 HALT SHALL enter HALTED with local_pc unchanged.
REQ-027 All other opcodes SHALL advance local_pc by PC_STEP, wrapping modulo 2^PC_WIDTH.
REQ-028 enable SHALL be combinational and high only for an active instruction whose opcode is not UNL-taken, JUMP, CALL, RET or HALT.
REQ-029 A non-active cycle SHALL change no state; a desynchronized cell waits until the global PC reaches local_pc (reconvergence), with zero extra latency on the match cycle.
REQ-030 Control transfers SHALL take effect on local_pc one cycle after the active instruction; synchronized is combinational.
REQ-031 In HALTED or FAULT, enable and state_change_enable SHALL be 0 regardless of inputs.

Reset
REQ-032 Asserting rst_n low SHALL asynchronously set local_pc=0, sp=0, fault=0, halted=0 and state=RUN, including mid-divergence or mid-call.
REQ-033 Stack entry contents SHALL NOT require reset; a RET never reads an entry at or above sp.

Structure
REQ-034 Opcode encodings (UNL and JUMP keep their existing values; CALL, RET and HALT are new), REG_MY, and the state enum SHALL live in the shared package cellcore_pkg.
REQ-035 The return stack SHALL be a separate sub-module, cell_return_stack, with push/pop/full/empty ports, parameterised by PC_WIDTH and STACK_DEPTH.

Verification
REQ-036 Reset, then active UNL with target_value=0 and imm8=0x20 at PC 0x004 -> local_pc=0x020, enable=0; global PCs 0x006 through 0x01E give enable=0; PC 0x020 gives synchronized=1 and enable=1.
REQ-037 CALL addr12=0x100 at PC 0x010, then RET at PC 0x100 -> sp goes 1 then 0, and local_pc goes 0x100 then 0x012.
REQ-038 With STACK_DEPTH=2, three nested CALLs -> third sets fault=1, sp stays 2, and subsequent matching instructions give enable=0.
REQ-039 RET at reset state -> fault=1 and local_pc=0 held.
REQ-040 With PC_WIDTH=12 and local_pc=0xFFE, an ordinary instruction wraps local_pc to 0x000; HALT -> halted=1, and only rst_n low clears it.
REQ-041 Asserting rst_n asynchronously mid-cycle while sp=3 and desynchronized -> all outputs reach reset values before the next clock edge.
